pipe_hazard_ctrl: RTL and testbench

Central stall/flush scheduler for the 5-stage pipeline. Drives the ID/EX register's `hazard` and `BranchBubble` inputs, plus the PC and IF/ID hold/flush controls. Handles three cases:
- load-use interlock
- multi-cycle mul/div occupancy of EX
- taken-branch flush windows

Sits beside the ID/EX register and takes register-field and control snapshots from the ID and EX stages.

---
 rtl/pipe_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use interlock, mul/div EX occupancy, taken-branch flush.
// Optional build macro HAZ_PERF_CNT_EN adds perf_lu/perf_md/perf_br event counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MD_LAT   = 4,
    parameter int unsigned BR_SLOTS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_ra,
    input  logic [4:0] id_rb,
    input  logic       id_use_rb,
    input  logic [4:0] ex_rw,
    input  logic       ex_regWr,
    input  logic       ex_memtoreg,
    input  logic       ex_muldiv,
    input  logic       ex_branch_taken,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       ifid_flush,
    output logic       hazard,
    output logic       BranchBubble,
    output logic       ex_hold,
    output logic       md_busy
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] perf_lu,
    output logic [31:0] perf_md,
    output logic [31:0] perf_br
`endif
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_MDBUSY = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    localparam logic [3:0] MD_CNT = 4'(MD_LAT - 2);
    localparam logic [3:0] BR_CNT = 4'(BR_SLOTS - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       lu;
    logic       pc_stall_c, ifid_stall_c, ifid_flush_c, hazard_c, bubble_c, ex_hold_c, md_busy_c;

    assign lu = ex_memtoreg & ex_regWr & (ex_rw != 5'd0) &
                ((ex_rw == id_ra) | (id_use_rb & (ex_rw == id_rb)));

    // The cnt==0 cycle of MDBUSY/FLUSH drives nothing: the mul/div result (or the
    // last bubble) leaves EX that cycle, so the total hold is MD_LAT-1 cycles.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_stall_c   = 1'b0;
        ifid_stall_c = 1'b0;
        ifid_flush_c = 1'b0;
        hazard_c     = 1'b0;
        bubble_c     = 1'b0;
        ex_hold_c    = 1'b0;
        md_busy_c    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    bubble_c     = 1'b1;
                    ifid_flush_c = 1'b1;
                    if (BR_SLOTS > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = BR_CNT;
                    end
                end else if (ex_muldiv) begin
                    ex_hold_c    = 1'b1;
                    pc_stall_c   = 1'b1;
                    ifid_stall_c = 1'b1;
                    md_busy_c    = 1'b1;
                    state_d      = ST_MDBUSY;
                    cnt_d        = MD_CNT;
                end else if (lu) begin
                    hazard_c     = 1'b1;
                    pc_stall_c   = 1'b1;
                    ifid_stall_c = 1'b1;
                end
            end
            ST_MDBUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    ex_hold_c    = 1'b1;
                    pc_stall_c   = 1'b1;
                    ifid_stall_c = 1'b1;
                    md_busy_c    = 1'b1;
                    cnt_d        = cnt_q - 4'd1;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    bubble_c     = 1'b1;
                    ifid_flush_c = 1'b1;
                    cnt_d        = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs are forced low for the whole time rst is high, not just after the edge.
    assign pc_stall     = pc_stall_c   & ~rst;
    assign ifid_stall   = ifid_stall_c & ~rst;
    assign ifid_flush   = ifid_flush_c & ~rst;
    assign hazard       = hazard_c     & ~rst;
    assign BranchBubble = bubble_c     & ~rst;
    assign ex_hold      = ex_hold_c    & ~rst;
    assign md_busy      = md_busy_c    & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_lu_q, perf_md_q, perf_br_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lu_q <= 32'd0;
            perf_md_q <= 32'd0;
            perf_br_q <= 32'd0;
        end else begin
            if (hazard)       perf_lu_q <= perf_lu_q + 32'd1;
            if (ex_hold)      perf_md_q <= perf_md_q + 32'd1;
            if (BranchBubble) perf_br_q <= perf_br_q + 32'd1;
        end
    end

    assign perf_lu = perf_lu_q;
    assign perf_md = perf_md_q;
    assign perf_br = perf_br_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MD_LAT=4, BR_SLOTS=2).
// Output vector order: {pc_stall, ifid_stall, ifid_flush, hazard, BranchBubble, ex_hold, md_busy}.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_ra, id_rb, ex_rw;
    logic       id_use_rb, ex_regWr, ex_memtoreg, ex_muldiv, ex_branch_taken;
    logic       pc_stall, ifid_stall, ifid_flush, hazard, BranchBubble, ex_hold, md_busy;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_lu, perf_md, perf_br;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [6:0] O_NONE = 7'b000_0000;
    localparam logic [6:0] O_LU   = 7'b110_1000;
    localparam logic [6:0] O_MD   = 7'b110_0011;
    localparam logic [6:0] O_BR   = 7'b001_0100;

    pipe_hazard_ctrl #(.MD_LAT(4), .BR_SLOTS(2)) dut (
        .clk(clk), .rst(rst),
        .id_ra(id_ra), .id_rb(id_rb), .id_use_rb(id_use_rb),
        .ex_rw(ex_rw), .ex_regWr(ex_regWr), .ex_memtoreg(ex_memtoreg),
        .ex_muldiv(ex_muldiv), .ex_branch_taken(ex_branch_taken),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .hazard(hazard), .BranchBubble(BranchBubble), .ex_hold(ex_hold), .md_busy(md_busy)
`ifdef HAZ_PERF_CNT_EN
        , .perf_lu(perf_lu), .perf_md(perf_md), .perf_br(perf_br)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {pc_stall, ifid_stall, ifid_flush, hazard, BranchBubble, ex_hold, md_busy};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge; inputs are then driven and outputs sampled at +4 ns.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_ra = 5'd0; id_rb = 5'd0; id_use_rb = 1'b0;
        ex_rw = 5'd0; ex_regWr = 1'b0; ex_memtoreg = 1'b0;
        ex_muldiv = 1'b0; ex_branch_taken = 1'b0;
    endtask

    task automatic set_lu();
        ex_memtoreg = 1'b1; ex_regWr = 1'b1; ex_rw = 5'd5; id_ra = 5'd5;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        // Reset: outputs held low even with branch and mul/div requests present.
        ex_muldiv = 1'b1; ex_branch_taken = 1'b1; set_lu();
        #3 check("reset_gates_outputs", 32'(outs()), 32'(O_NONE));
        cyc();
        cyc();
        rst = 1'b0;
        clear_inputs();
        #3 check("idle_after_reset", 32'(outs()), 32'(O_NONE));

        // Load-use on rs, then ex_rw==0 and non-writing EX cases.
        cyc(); set_lu();
        #3 check("lu_rs", 32'(outs()), 32'(O_LU));
        cyc(); ex_rw = 5'd0; id_ra = 5'd0;
        #3 check("lu_r0_ignored", 32'(outs()), 32'(O_NONE));
        cyc(); set_lu(); ex_regWr = 1'b0;
        #3 check("lu_no_regwr", 32'(outs()), 32'(O_NONE));
        cyc(); set_lu(); ex_memtoreg = 1'b0;
        #3 check("lu_not_load", 32'(outs()), 32'(O_NONE));

        // Load-use on rt, gated by id_use_rb.
        cyc(); clear_inputs();
        ex_memtoreg = 1'b1; ex_regWr = 1'b1; ex_rw = 5'd7; id_rb = 5'd7; id_ra = 5'd3;
        #3 check("lu_rt_unused", 32'(outs()), 32'(O_NONE));
        cyc(); id_use_rb = 1'b1;
        #3 check("lu_rt_used", 32'(outs()), 32'(O_LU));

        // Mul/div pulse: three hold cycles, release cycle ignores lu, then RUN again.
        cyc(); clear_inputs(); ex_muldiv = 1'b1;
        #3 check("md_entry", 32'(outs()), 32'(O_MD));
        cyc(); ex_muldiv = 1'b0; set_lu();
        #3 check("md_busy1_lu_ignored", 32'(outs()), 32'(O_MD));
        cyc();
        #3 check("md_busy2", 32'(outs()), 32'(O_MD));
        cyc();
        #3 check("md_release", 32'(outs()), 32'(O_NONE));
        cyc();
        #3 check("md_back_to_run_lu", 32'(outs()), 32'(O_LU));

        // Mul/div held high by the same instruction for its whole EX residency.
        cyc(); clear_inputs(); ex_muldiv = 1'b1;
        #3 check("md_hold_entry", 32'(outs()), 32'(O_MD));
        cyc(); #3 check("md_hold_c1", 32'(outs()), 32'(O_MD));
        cyc(); #3 check("md_hold_c2", 32'(outs()), 32'(O_MD));
        cyc(); #3 check("md_hold_release", 32'(outs()), 32'(O_NONE));
        cyc(); ex_muldiv = 1'b0;
        #3 check("md_hold_idle", 32'(outs()), 32'(O_NONE));

        // Taken branch with coincident lu: two bubble cycles, no pc_stall, hazard suppressed.
        cyc(); set_lu(); ex_branch_taken = 1'b1;
        #3 check("br_resolve_cycle", 32'(outs()), 32'(O_BR));
        cyc(); ex_branch_taken = 1'b0;
        #3 check("br_flush_slot", 32'(outs()), 32'(O_BR));
        cyc();
        #3 check("br_flush_end", 32'(outs()), 32'(O_NONE));
        cyc();
        #3 check("br_back_to_run_lu", 32'(outs()), 32'(O_LU));

        // Branch and mul/div together: branch wins, FLUSH ignores mul/div.
        cyc(); clear_inputs(); ex_branch_taken = 1'b1; ex_muldiv = 1'b1;
        #3 check("br_md_resolve", 32'(outs()), 32'(O_BR));
        cyc(); ex_branch_taken = 1'b0;
        #3 check("br_md_flush_md_ignored", 32'(outs()), 32'(O_BR));
        cyc(); ex_muldiv = 1'b0;
        #3 check("br_md_flush_end", 32'(outs()), 32'(O_NONE));
        cyc();
        #3 check("br_md_idle", 32'(outs()), 32'(O_NONE));

`ifdef HAZ_PERF_CNT_EN
        check("perf_lu_counted", 32'(perf_lu != 32'd0), 32'd1);
        check("perf_md_counted", 32'(perf_md != 32'd0), 32'd1);
        check("perf_br_counted", 32'(perf_br != 32'd0), 32'd1);
`endif

        // Asynchronous reset in the second MDBUSY cycle.
        cyc(); ex_muldiv = 1'b1;
        #3 check("rst_md_entry", 32'(outs()), 32'(O_MD));
        cyc(); #3 check("rst_md_busy1", 32'(outs()), 32'(O_MD));
        cyc(); #3 check("rst_md_busy2", 32'(outs()), 32'(O_MD));
        #1 rst = 1'b1;
        #1 check("rst_async_drop", 32'(outs()), 32'(O_NONE));
`ifdef HAZ_PERF_CNT_EN
        check("perf_lu_cleared", perf_lu, 32'd0);
        check("perf_md_cleared", perf_md, 32'd0);
        check("perf_br_cleared", perf_br, 32'd0);
`endif
        cyc(); #3 check("rst_held", 32'(outs()), 32'(O_NONE));
        cyc(); rst = 1'b0; ex_muldiv = 1'b0;
        #3 check("rst_release_run", 32'(outs()), 32'(O_NONE));
        cyc(); #3 check("rst_no_residual", 32'(outs()), 32'(O_NONE));
        cyc(); set_lu();
        #3 check("rst_then_lu", 32'(outs()), 32'(O_LU));
        cyc(); clear_inputs(); ex_muldiv = 1'b1;
        #3 check("rst_then_md_entry", 32'(outs()), 32'(O_MD));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
